seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Run-time-programmable serial pattern detector with its own sequencing controller.
//  - Accepts a pattern, length, overlap mode and match target over a valid/ready config port.
//  - Arms on start, scans a gated serial bit stream, counts matches.
//  - Ends a run on reaching the target, on an idle timeout, or on abort.
//  - Sits beside the fixed Moore detectors as the configurable front end for bit-stream checking.
// PARAMETERS
//  PAT_W  8    max pattern length in bits (>=2)
//  LEN_W  4    width of cfg_len; holds 0..PAT_W
//  CNT_W  8    width of match counter and target
//  TO_CYC 16   consecutive RUN cycles with x_valid=0 that trigger a timeout (>=1)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-low reset
//  cfg_valid    in   1      config offer
//  cfg_ready    out  1      config accepted when cfg_valid & cfg_ready
//  cfg_pattern  in   PAT_W  pattern; bit[cfg_len-1] is compared against the oldest bit, bit[0] against the newest
//  cfg_len      in   LEN_W  pattern length
//  cfg_overlap  in   1      1 = overlapping matches allowed
//  cfg_target   in   CNT_W  matches needed to finish; 0 = run until abort or timeout
//  start        in   1      arm request
//  abort        in   1      terminate request
//  x_valid      in   1      serial bit qualifier
//  x            in   1      serial data bit
//  match        out  1      one-cycle pulse per detected match
//  match_cnt    out  CNT_W  matches in current or last run; saturates at all-ones
//  busy         out  1      high in RUN
//  done         out  1      one-cycle pulse on entry to DONE
//  timeout      out  1      sticky; set on timeout end, cleared on next start
//  cfg_err      out  1      sticky; set on rejected config, cleared on next accepted config
//  cst          out  3      current state: IDLE=0, RUN=1, DONE=2
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state IDLE; all outputs 0 except cfg_ready=1; cfg_ready=1 only in IDLE.
//   - Config registers cleared; loaded flag cleared.
//  Config handshake (IDLE only):
//   - A config is accepted on cfg_valid & cfg_ready.
//   - cfg_len==0 or cfg_len>PAT_W: config rejected, cfg_err=1, loaded flag unchanged.
//   - Otherwise: registers load, loaded=1, cfg_err=0.
//  IDLE -> RUN:
//   - On start & loaded & !abort.
//   - History register, fill count, match_cnt and idle counter cleared; timeout cleared.
//   - start without a loaded config is ignored.
//  RUN, each cycle with x_valid=1:
//   - x shifts into history (newest at bit 0); fill count increments, saturating at cfg_len.
//   - Match condition: fill count reaches cfg_len and history[cfg_len-1:0]==cfg_pattern[cfg_len-1:0].
//     Evaluated including the bit arriving this cycle.
//   - On a match: match pulses on the next cycle (registered output, latency 1); match_cnt increments.
//   - cfg_overlap=0: a match clears the fill count, so the next match needs cfg_len fresh bits.
//  RUN idle timeout:
//   - Idle counter increments on x_valid=0 and clears on x_valid=1.
//   - Reaching TO_CYC: timeout=1, go to DONE.
//  RUN -> DONE:
//   - On the cycle match_cnt becomes equal to cfg_target (target != 0).
//   - The final match pulse and the done pulse appear on the same cycle.
//  DONE -> IDLE:
//   - Unconditional on the next cycle.
//   - match_cnt holds its value until the next start.
//  abort:
//   - In RUN: go to IDLE next cycle; no done pulse.
//   - Priority: abort > target reached > timeout. A match completing in the abort cycle still pulses match and counts.
//   - abort outside RUN is ignored.
//  start while in RUN or DONE is ignored.
//  Mid-operation reset returns to the reset state immediately; the config must be reloaded.
// TESTING
//  1. cfg 1010, len 4, overlap=1, target 0; start; stream 1,0,1,0,1,0 -> match after bits 4 and 6; match_cnt=2.
//  2. Same stream with overlap=0 -> single match after bit 4; match_cnt=1.
//  3. target=2, overlap=0, stream 10101010 -> matches after bits 4 and 8; done pulse with the 2nd match; IDLE next cycle.
//  4. TO_CYC=16, x_valid low for 16 cycles in RUN -> timeout=1, done pulse, cst 1->2->0.
//  5. cfg_len=0, then cfg_len=9 with PAT_W=8 -> cfg_err=1, start ignored (cst stays 0); a valid cfg then clears cfg_err.
//  6. abort and start/complete-match in the same cycle; rst low mid-RUN -> outputs and cst=0 without waiting for a clock edge.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Config, control, serial-stream and status bundle of seq_detect_ctrl.
interface seq_detect_ctrl_if #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             x_valid;
  logic             x;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             cfg_err;
  logic [2:0]       cst;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
           start, abort, x_valid, x,
    input  cfg_ready, match, match_cnt, busy, done, timeout, cfg_err, cst
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
           start, abort, x_valid, x,
    output cfg_ready, match, match_cnt, busy, done, timeout, cfg_err, cst
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run-time-programmable serial pattern detector with its own IDLE/RUN/DONE
// sequencer: loads a pattern over a valid/ready port, scans a gated bit stream, counts matches.
module seq_detect_ctrl #(
  parameter int unsigned PAT_W  = 8,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned TO_CYC = 16
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);
  localparam int unsigned IDL_W = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DONE = 3'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d, hist_q, hist_d, hist_nx, mask;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_nx;
  logic [CNT_W-1:0]   tgt_q, tgt_d, cnt_q, cnt_d, cnt_nx;
  logic [IDL_W-1:0]   idle_q, idle_d, idle_nx;
  logic               ovl_q, ovl_d, loaded_q, loaded_d, cfg_err_q, cfg_err_d;
  logic               match_q, match_d, done_q, done_d, timeout_q, timeout_d;
  logic               hit, tgt_hit, to_hit;

  // Only the low len_q history bits take part in the compare.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    tgt_d     = tgt_q;
    loaded_d  = loaded_q;
    cfg_err_d = cfg_err_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    timeout_d = timeout_q;
    match_d   = 1'b0;
    done_d    = 1'b0;

    // Match evaluation includes the bit arriving this cycle.
    hist_nx = {hist_q[PAT_W-2:0], bus.x};
    fill_nx = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    hit     = bus.x_valid && (fill_nx == len_q) && (((hist_nx ^ pat_q) & mask) == '0);
    cnt_nx  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    idle_nx = bus.x_valid ? '0 : idle_q + IDL_W'(1);
    tgt_hit = hit && (tgt_q != '0) && (cnt_nx == tgt_q);
    to_hit  = !bus.x_valid && (idle_nx == IDL_W'(TO_CYC));

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          if ((bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(PAT_W))) begin
            cfg_err_d = 1'b1;
          end else begin
            pat_d     = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            ovl_d     = bus.cfg_overlap;
            tgt_d     = bus.cfg_target;
            loaded_d  = 1'b1;
            cfg_err_d = 1'b0;
          end
        end
        if (bus.start && loaded_q && !bus.abort) begin
          state_d   = ST_RUN;
          hist_d    = '0;
          fill_d    = '0;
          cnt_d     = '0;
          idle_d    = '0;
          timeout_d = 1'b0;
        end
      end
      ST_RUN: begin
        idle_d = idle_nx;
        if (bus.x_valid) begin
          hist_d = hist_nx;
          fill_d = fill_nx;
        end
        if (hit) begin
          match_d = 1'b1;
          cnt_d   = cnt_nx;
          if (!ovl_q) fill_d = '0;
        end
        // abort beats target, target beats timeout
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (tgt_hit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (to_hit) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
      loaded_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      tgt_q     <= tgt_d;
      loaded_q  <= loaded_d;
      cfg_err_q <= cfg_err_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
      match_q   <= match_d;
      done_q    <= done_d;
    end
  end

  assign bus.cfg_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.cst       = state_q;
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus random traffic
// against a queue-based model of the detector's rules.
module tb_seq_detect_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_detect_ctrl_if bus ();
  seq_detect_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         m_st, m_len, m_tgt, m_cnt, m_idle;
  bit         m_loaded, m_err, m_to, m_match, m_done, m_ovl;
  logic [7:0] m_pat;
  bit         q_bits[$];

  localparam logic [16:0] RST_VEC = 17'h00800;

  function automatic void model_reset();
    m_st = 0; m_len = 0; m_tgt = 0; m_cnt = 0; m_idle = 0;
    m_loaded = 0; m_err = 0; m_to = 0; m_match = 0; m_done = 0; m_ovl = 0;
    m_pat = '0;
    q_bits.delete();
  endfunction

  function automatic bit tail_matches();
    int n = q_bits.size();
    if (n < m_len) return 0;
    for (int k = 0; k < m_len; k++)
      if (q_bits[n-1-k] != m_pat[k]) return 0;
    return 1;
  endfunction

  function automatic void model_update();
    bit was_loaded = m_loaded;
    bit reached = 0;
    bit tmo = 0;
    m_match = 0;
    m_done  = 0;
    case (m_st)
      0: begin
        if (bus.cfg_valid) begin
          if (bus.cfg_len == 0 || bus.cfg_len > 8) m_err = 1;
          else begin
            m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
            m_ovl = bus.cfg_overlap; m_tgt = int'(bus.cfg_target);
            m_loaded = 1; m_err = 0;
          end
        end
        if (bus.start && was_loaded && !bus.abort) begin
          m_st = 1; q_bits.delete(); m_cnt = 0; m_idle = 0; m_to = 0;
        end
      end
      1: begin
        if (bus.x_valid) begin
          m_idle = 0;
          q_bits.push_back(bus.x);
          if (q_bits.size() > 8) void'(q_bits.pop_front());
          if (tail_matches()) begin
            m_match = 1;
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) q_bits.delete();
            reached = (m_tgt != 0) && (m_cnt == m_tgt);
          end
        end else begin
          m_idle++;
          tmo = (m_idle == 16);
        end
        if (bus.abort) m_st = 0;
        else if (reached) begin m_st = 2; m_done = 1; end
        else if (tmo) begin m_st = 2; m_done = 1; m_to = 1; end
      end
      default: m_st = 0;
    endcase
  endfunction

  function automatic logic [16:0] exp_vec();
    return {m_match, m_done, (m_st == 1), m_to, m_err, (m_st == 0), 3'(m_st), 8'(m_cnt)};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.match, bus.done, bus.busy, bus.timeout, bus.cfg_err, bus.cfg_ready,
            bus.cst, bus.match_cnt};
  endfunction

  task automatic quiet_inputs();
    bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    bus.cfg_target = '0; bus.start = 0; bus.abort = 0; bus.x_valid = 0; bus.x = 0;
  endtask

  // Advance one clock with the currently driven inputs; lands 1 time unit after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                          input logic [7:0] t);
    bus.cfg_valid = 1; bus.cfg_pattern = p; bus.cfg_len = l;
    bus.cfg_overlap = o; bus.cfg_target = t;
    step();
    bus.cfg_valid = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1; step(); bus.start = 0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1; step(); bus.abort = 0;
  endtask

  task automatic do_reset();
    #2 rst = 0;
    model_reset();
    #1 rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    quiet_inputs();
    model_reset();
    #12;
    n_vec++;
    if (obs_vec() !== RST_VEC) begin
      n_err++; $display("FAIL reset: got %h exp %h", obs_vec(), RST_VEC);
    end
    rst = 1;
    @(posedge clk); #1;
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_release: got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic run_stream(input string name, input logic [7:0] bits, input int nbits,
                            output int pulses);
    pulses = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.x_valid = 1; bus.x = bits[i];
      step();
      if (bus.match === 1'b1) pulses++;
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL %s bit%0d: got %h exp %h", name, nbits - i, obs_vec(), exp_vec());
      end
    end
    bus.x_valid = 0;
  endtask

  task automatic test_overlap();
    int pulses;
    logic [7:0] s = 8'b0010_1010;
    send_cfg(8'h0A, 4'd4, 1'b1, 8'd0);
    pulse_start();
    run_stream("overlap", s, 6, pulses);
    n_vec++;
    if (pulses != 2 || bus.match_cnt !== 8'd2) begin
      n_err++; $display("FAIL overlap_count: got pulses=%0d cnt=%0d exp 2/2", pulses, bus.match_cnt);
    end
    pulse_abort();
  endtask

  task automatic test_no_overlap();
    int pulses;
    logic [7:0] s = 8'b0010_1010;
    send_cfg(8'h0A, 4'd4, 1'b0, 8'd0);
    pulse_start();
    run_stream("no_overlap", s, 6, pulses);
    n_vec++;
    if (pulses != 1 || bus.match_cnt !== 8'd1) begin
      n_err++; $display("FAIL no_overlap_count: got pulses=%0d cnt=%0d exp 1/1", pulses, bus.match_cnt);
    end
    pulse_abort();
  endtask

  task automatic test_target();
    int pulses;
    logic [7:0] s = 8'b1010_1010;
    send_cfg(8'h0A, 4'd4, 1'b0, 8'd2);
    pulse_start();
    run_stream("target", s, 8, pulses);
    n_vec++;
    if ({bus.match, bus.done, bus.cst, bus.match_cnt} !== {1'b1, 1'b1, 3'd2, 8'd2}) begin
      n_err++; $display("FAIL target_done: got m=%b d=%b cst=%0d cnt=%0d exp 1 1 2 2",
                        bus.match, bus.done, bus.cst, bus.match_cnt);
    end
    step();
    n_vec++;
    if (bus.cst !== 3'd0 || bus.match_cnt !== 8'd2 || obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL target_idle: got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_timeout();
    send_cfg(8'h0A, 4'd4, 1'b1, 8'd0);
    pulse_start();
    for (int i = 1; i <= 16; i++) begin
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL timeout_cyc%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({bus.done, bus.timeout, bus.cst} !== {1'b1, 1'b1, 3'd2}) begin
      n_err++; $display("FAIL timeout_end: got d=%b to=%b cst=%0d exp 1 1 2",
                        bus.done, bus.timeout, bus.cst);
    end
    step();
    n_vec++;
    if ({bus.timeout, bus.cst} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL timeout_sticky: got to=%b cst=%0d exp 1 0", bus.timeout, bus.cst);
    end
    pulse_start();
    n_vec++;
    if ({bus.timeout, bus.cst} !== {1'b0, 3'd1}) begin
      n_err++; $display("FAIL timeout_clear: got to=%b cst=%0d exp 0 1", bus.timeout, bus.cst);
    end
    pulse_abort();
  endtask

  task automatic test_cfg_err();
    do_reset();
    send_cfg(8'h0A, 4'd0, 1'b0, 8'd0);
    pulse_start();
    n_vec++;
    if ({bus.cfg_err, bus.cst} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL cfg_len0: got err=%b cst=%0d exp 1 0", bus.cfg_err, bus.cst);
    end
    send_cfg(8'h0A, 4'd9, 1'b0, 8'd0);
    pulse_start();
    n_vec++;
    if ({bus.cfg_err, bus.cst} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL cfg_len9: got err=%b cst=%0d exp 1 0", bus.cfg_err, bus.cst);
    end
    send_cfg(8'hA5, 4'd8, 1'b1, 8'd0);
    n_vec++;
    if (bus.cfg_err !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL cfg_ok: got %h exp %h", obs_vec(), exp_vec());
    end
    pulse_start();
    n_vec++;
    if (bus.cst !== 3'd1) begin
      n_err++; $display("FAIL cfg_ok_start: got cst=%0d exp 1", bus.cst);
    end
    pulse_abort();
  endtask

  task automatic test_abort();
    int pulses;
    logic [7:0] s = 8'b0000_0101;
    send_cfg(8'h0A, 4'd4, 1'b1, 8'd1);
    bus.start = 1; bus.abort = 1; step(); bus.start = 0; bus.abort = 0;
    n_vec++;
    if (bus.cst !== 3'd0) begin
      n_err++; $display("FAIL abort_with_start: got cst=%0d exp 0", bus.cst);
    end
    pulse_start();
    run_stream("abort_pre", s, 3, pulses);
    bus.x_valid = 1; bus.x = 0; bus.abort = 1;
    step();
    bus.x_valid = 0; bus.abort = 0;
    n_vec++;
    if ({bus.match, bus.done, bus.cst, bus.match_cnt} !== {1'b1, 1'b0, 3'd0, 8'd1}) begin
      n_err++; $display("FAIL abort_match: got m=%b d=%b cst=%0d cnt=%0d exp 1 0 0 1",
                        bus.match, bus.done, bus.cst, bus.match_cnt);
    end
    // asynchronous reset in the middle of a run
    pulse_start();
    run_stream("areset_pre", s, 3, pulses);
    #2 rst = 0;
    #1;
    model_reset();
    n_vec++;
    if (obs_vec() !== RST_VEC) begin
      n_err++; $display("FAIL async_reset: got %h exp %h", obs_vec(), RST_VEC);
    end
    #1 rst = 1;
    @(posedge clk); #1;
    pulse_start();
    n_vec++;
    if (bus.cst !== 3'd0 || obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_unloaded: got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_saturation();
    send_cfg(8'h01, 4'd1, 1'b1, 8'd0);
    pulse_start();
    for (int i = 1; i <= 260; i++) begin
      bus.x_valid = 1; bus.x = 1;
      step();
      if (obs_vec() !== exp_vec()) begin
        n_vec++; n_err++;
        $display("FAIL sat_bit%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
    bus.x_valid = 0;
    n_vec++;
    if (bus.match_cnt !== 8'hFF || bus.match !== 1'b1) begin
      n_err++; $display("FAIL saturate: got cnt=%0d m=%b exp 255 1", bus.match_cnt, bus.match);
    end
    pulse_abort();
  endtask

  task automatic test_random();
    bit quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 80 == 0) quiet = ($urandom_range(0, 2) == 0);
      bus.cfg_valid   = ($urandom_range(0, 5) == 0);
      bus.cfg_pattern = 8'($urandom);
      bus.cfg_len     = 4'($urandom_range(0, 9));
      bus.cfg_overlap = 1'($urandom);
      bus.cfg_target  = 8'($urandom_range(0, 4));
      bus.start       = ($urandom_range(0, 3) == 0);
      bus.abort       = ($urandom_range(0, 60) == 0);
      bus.x_valid     = quiet ? ($urandom_range(0, 12) == 0) : ($urandom_range(0, 3) != 0);
      bus.x           = 1'($urandom);
      step();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_cyc%0d: got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_target();
    test_timeout();
    test_cfg_err();
    test_abort();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
